// File: rtl/tristate_bus_reader.sv
// Receiver for the shared 1-bit tri-state bus: assembles LSB-first frames of
// WIDTH data bits plus an even-parity bit into a valid/ready output register.
module tristate_bus_reader #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bus_en,
    input  logic             bus_d,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun,
    input  logic             clr_overrun
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q && !out_ready;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = overrun_q && !clr_overrun;

        unique case (state_q)
            IDLE: begin
                if (bus_en) begin
                    shift_d    = '0;
                    shift_d[0] = bus_d;
                    cnt_d      = CW'(1);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (bus_en) begin
                    shift_d[cnt_q] = bus_d;
                    cnt_d          = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_d = PARITY;
                end else begin
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            PARITY: begin
                cnt_d   = '0;
                state_d = IDLE;
                if (!bus_en) begin
                    frame_err_d = 1'b1;
                end else if (^{shift_q, bus_d}) begin
                    parity_err_d = 1'b1;
                end else if (!out_valid_q || out_ready) begin
                    out_data_d  = shift_q;
                    out_valid_d = 1'b1;
                end else begin
                    // Set beats a simultaneous clr_overrun.
                    overrun_d = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_tristate_bus_reader.sv
// Directed, table-driven bench for tristate_bus_reader (WIDTH=8): one row per
// clock, outputs checked 1 time unit after the rising edge.
module tb_tristate_bus_reader;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             bus_en;
    logic             bus_d;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             parity_err;
    logic             frame_err;
    logic             overrun;
    logic             clr_overrun;

    int n_tests = 0;
    int n_fail  = 0;

    tristate_bus_reader #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_en     (bus_en),
        .bus_d      (bus_d),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       d;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [7:0] ed;
        logic       ep;
        logic       ef;
        logic       eo;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic d, input logic rdy, input logic clr,
                       input logic ev, input logic [7:0] ed, input logic ep,
                       input logic ef, input logic eo);
        vec_t v;
        v.en = en; v.d = d; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ed = ed; v.ep = ep; v.ef = ef; v.eo = eo;
        vecs.push_back(v);
    endtask

    // Eight data rows then the parity row; expectations supplied by the caller.
    task automatic add_frame(input logic [7:0] word, input logic par, input logic rdy,
                             input logic ev_in, input logic [7:0] ed_in, input logic eo_in,
                             input logic clr_end, input logic ev_end, input logic [7:0] ed_end,
                             input logic ep_end, input logic eo_end);
        for (int i = 0; i < 8; i++)
            add(1'b1, word[i], rdy, 1'b0, ev_in, ed_in, 1'b0, 1'b0, eo_in);
        add(1'b1, par, rdy, clr_end, ev_end, ed_end, ep_end, 1'b0, eo_end);
    endtask

    task automatic chk(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int row, input logic ev,
                           input logic [7:0] ed, input logic ep, input logic ef,
                           input logic eo);
        chk({tag, ".valid"}, row, 32'(out_valid), 32'(ev));
        chk({tag, ".data"}, row, 32'(out_data), 32'(ed));
        chk({tag, ".parity_err"}, row, 32'(parity_err), 32'(ep));
        chk({tag, ".frame_err"}, row, 32'(frame_err), 32'(ef));
        chk({tag, ".overrun"}, row, 32'(overrun), 32'(eo));
    endtask

    task automatic cycle(input logic en, input logic d, input logic rdy, input logic clr);
        bus_en = en; bus_d = d; out_ready = rdy; clr_overrun = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] w;

        rst_n = 1'b0; bus_en = 1'b0; bus_d = 1'b0; out_ready = 1'b0; clr_overrun = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("post_reset", 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // 1: good word 0xA5, consumed right away
        add_frame(8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
        // 2: 0xA5 with wrong parity
        add_frame(8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
        // 3: enable drops after 3 bits, then 0x3C
        for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
        add_frame(8'h3C, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        // 4: consumer stalled, second word dropped, then cleared
        add_frame(8'h01, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        add_frame(8'h02, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        // drop coinciding with clr_overrun: set wins
        add_frame(8'h03, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
        // 5: back-to-back frames, 18 cycles of bus_en
        add_frame(8'h01, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        add_frame(8'hFF, 1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        // enable lost on the parity slot
        for (int i = 0; i < 8; i++) add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].en, vecs[i].d, vecs[i].rdy, vecs[i].clr);
            chk_all("vec", i, vecs[i].ev, vecs[i].ed, vecs[i].ep, vecs[i].ef, vecs[i].eo);
        end

        // 6: async reset after bit 5 of a frame, then a clean 0x5A
        w = 8'h5A;
        for (int i = 0; i < 6; i++) cycle(1'b1, w[i], 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_all("in_reset", 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        bus_en = 1'b0;
        @(posedge clk);
        #1;
        chk_all("in_reset", 1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            chk_all("after_reset", i, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) cycle(1'b1, w[i], 1'b1, 1'b0);
        chk_all("5A_bits", 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("5A_word", 0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("5A_taken", 0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
